// File: rtl/ahmes_alu_seq_if.sv
// -----------------------------------------------------------------------------
// ahmes_alu_seq_if
//
// Purpose: bundles the request/response signals of the Ahmes sequenced ALU so
// the ALU core, the control unit and a bench can share one connection object.
//
// Handshake (one rule for the whole interface):
//   - The master raises start together with op, a, b and the five *_cur flags.
//     The slave accepts them on the rising edge where it is idle (busy=0).
//   - While busy=1 the slave ignores start. Nothing is queued.
//   - done pulses for exactly one cycle when the operation completes.
//     load_flags_en and acc_load can only be high in that same cycle.
//   - result and n_in..v_in hold their values until the next completion
//     that writes them.
//
// Signals:
//   start               master -> slave  operation request
//   op[3:0]             master -> slave  opcode
//   a, b [WIDTH-1:0]    master -> slave  accumulator / memory operands
//   n_cur..v_cur        master -> slave  current status-register outputs
//   result[WIDTH-1:0]   slave -> master  registered result
//   n_in..v_in          slave -> master  flags for the status register
//   load_flags_en       slave -> master  one-cycle flag load strobe
//   acc_load            slave -> master  one-cycle accumulator write strobe
//   busy                slave -> master  operation in flight
//   done                slave -> master  one-cycle completion pulse
// -----------------------------------------------------------------------------
interface ahmes_alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             n_cur;
    logic             z_cur;
    logic             c_cur;
    logic             b_cur;
    logic             v_cur;

    logic [WIDTH-1:0] result;
    logic             n_in;
    logic             z_in;
    logic             c_in;
    logic             b_in;
    logic             v_in;
    logic             load_flags_en;
    logic             acc_load;
    logic             busy;
    logic             done;

    modport master (
        output start, op, a, b, n_cur, z_cur, c_cur, b_cur, v_cur,
        input  result, n_in, z_in, c_in, b_in, v_in,
        input  load_flags_en, acc_load, busy, done
    );

    modport slave (
        input  start, op, a, b, n_cur, z_cur, c_cur, b_cur, v_cur,
        output result, n_in, z_in, c_in, b_in, v_in,
        output load_flags_en, acc_load, busy, done
    );
endinterface

// File: rtl/ahmes_alu_seq.sv
// -----------------------------------------------------------------------------
// ahmes_alu_seq
//
// Purpose: sequenced WIDTH-bit ALU for the Ahmes CPU. One accumulator
// operation per accepted start. Produces a full NZCBV flag set for the status
// register. Flags an opcode does not touch are copied from the *_cur values
// latched at start, because the status register always loads all five.
//
// Timing: start accepted at edge E0 (IDLE -> EXEC). Result and flags are
// registered at E1 (EXEC -> DONE). done, load_flags_en and acc_load are high
// during the DONE cycle. The state returns to IDLE at E2, which is also the
// edge where the status register samples the flags.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high; overrides every other input
//   bus        ahmes_alu_seq_if.slave (see interface file for the handshake)
//   state_dbg  current FSM state (0=IDLE, 1=EXEC, 2=DONE)
//
// Optional build macro:
//   ALU_CMP_EN  when defined, opcode 0xA is CMP. CMP computes a-b with the SUB
//               flag rules and loads the flags. It does not write the
//               accumulator, but the result output still shows the
//               difference. When the macro is undefined, 0xA is an unused
//               opcode.
// -----------------------------------------------------------------------------
module ahmes_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    ahmes_alu_seq_if.slave      bus,
    output logic [1:0]          state_dbg
);

    // FSM encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Opcodes
    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_NOT = 4'h5;
    localparam logic [3:0] OP_SHR = 4'h6;
    localparam logic [3:0] OP_SHL = 4'h7;
    localparam logic [3:0] OP_ROR = 4'h8;
    localparam logic [3:0] OP_ROL = 4'h9;
`ifdef ALU_CMP_EN
    localparam logic [3:0] OP_CMP = 4'hA;
`endif

    // Bit positions inside the packed {N,Z,C,B,V} flag vector
    localparam int F_N = 4;
    localparam int F_Z = 3;
    localparam int F_C = 2;
    localparam int F_B = 1;
    localparam int F_V = 0;

    localparam int MSB = WIDTH - 1;

    // -------------------------------------------------------------------------
    // State and operand registers
    // -------------------------------------------------------------------------
    logic [1:0]       state_q,  state_d;
    logic [3:0]       op_q,     op_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [4:0]       cur_q,    cur_d;

    // Output registers
    logic [WIDTH-1:0] result_q, result_d;
    logic [4:0]       flags_q,  flags_d;
    logic             lfe_q,    lfe_d;
    logic             acc_q,    acc_d;
    logic             done_q,   done_d;

    // -------------------------------------------------------------------------
    // Datapath: evaluated from the latched operands only. It is used solely
    // in EXEC, so inputs that change after start have no effect.
    // -------------------------------------------------------------------------
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic [WIDTH-1:0] alu_r;
    logic [4:0]       alu_f;
    logic             alu_valid;   // opcode loads result and flags
    logic             alu_wr_acc;  // opcode also writes the accumulator

    // Carry and borrow come from the extra top bit of a WIDTH+1-bit
    // computation. diff_w[WIDTH] is set exactly when a < b (unsigned).
    assign sum_w  = {1'b0, a_q} + {1'b0, b_q};
    assign diff_w = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        alu_r      = '0;
        alu_f      = cur_q;   // untouched flags pass through
        alu_valid  = 1'b1;
        alu_wr_acc = 1'b1;

        case (op_q)
            OP_LDA: alu_r = b_q;
            OP_ADD: begin
                alu_r      = sum_w[WIDTH-1:0];
                alu_f[F_C] = sum_w[WIDTH];
                alu_f[F_V] = (a_q[MSB] == b_q[MSB]) && (alu_r[MSB] != a_q[MSB]);
            end
            OP_SUB: begin
                alu_r      = diff_w[WIDTH-1:0];
                alu_f[F_B] = diff_w[WIDTH];
                alu_f[F_V] = (a_q[MSB] != b_q[MSB]) && (alu_r[MSB] != a_q[MSB]);
            end
`ifdef ALU_CMP_EN
            OP_CMP: begin
                alu_r      = diff_w[WIDTH-1:0];
                alu_f[F_B] = diff_w[WIDTH];
                alu_f[F_V] = (a_q[MSB] != b_q[MSB]) && (alu_r[MSB] != a_q[MSB]);
                alu_wr_acc = 1'b0;
            end
`endif
            OP_OR:  alu_r = a_q | b_q;
            OP_AND: alu_r = a_q & b_q;
            OP_NOT: alu_r = ~a_q;
            OP_SHR: begin
                alu_r      = {1'b0, a_q[MSB:1]};
                alu_f[F_C] = a_q[0];
            end
            OP_SHL: begin
                alu_r      = {a_q[MSB-1:0], 1'b0};
                alu_f[F_C] = a_q[MSB];
            end
            // Rotates go through the carry latched at start.
            OP_ROR: begin
                alu_r      = {cur_q[F_C], a_q[MSB:1]};
                alu_f[F_C] = a_q[0];
            end
            OP_ROL: begin
                alu_r      = {a_q[MSB-1:0], cur_q[F_C]};
                alu_f[F_C] = a_q[MSB];
            end
            default: begin
                alu_valid  = 1'b0;
                alu_wr_acc = 1'b0;
            end
        endcase

        // Every valid opcode updates N and Z from its result.
        if (alu_valid) begin
            alu_f[F_N] = alu_r[MSB];
            alu_f[F_Z] = (alu_r == '0);
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        cur_d    = cur_q;
        result_d = result_q;
        flags_d  = flags_q;
        // Strobes default low, so they can only be high in the DONE cycle.
        lfe_d    = 1'b0;
        acc_d    = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    cur_d   = {bus.n_cur, bus.z_cur, bus.c_cur, bus.b_cur, bus.v_cur};
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // An unused opcode still completes, but it leaves result and
                // flags untouched and raises no load strobe.
                if (alu_valid) begin
                    result_d = alu_r;
                    flags_d  = alu_f;
                    lfe_d    = 1'b1;
                    acc_d    = alu_wr_acc;
                end
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                // start is not looked at here, so requests are never queued.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cur_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
            lfe_q    <= 1'b0;
            acc_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cur_q    <= cur_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            lfe_q    <= lfe_d;
            acc_q    <= acc_d;
            done_q   <= done_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.result        = result_q;
    assign bus.n_in          = flags_q[F_N];
    assign bus.z_in          = flags_q[F_Z];
    assign bus.c_in          = flags_q[F_C];
    assign bus.b_in          = flags_q[F_B];
    assign bus.v_in          = flags_q[F_V];
    assign bus.load_flags_en = lfe_q;
    assign bus.acc_load      = acc_q;
    assign bus.done          = done_q;
    assign bus.busy          = (state_q != S_IDLE);
    assign state_dbg         = state_q;

endmodule

// File: doc/ahmes_alu_seq.md
Name: ahmes_alu_seq

Overview:
- Sequenced 8-bit ALU for the Ahmes CPU. Executes one accumulator operation per start request.
- Produces the result plus a complete NZCBV flag set, and raises a one-cycle load_flags_en that drives the status register directly downstream.
- Flags not affected by an opcode are passed through from the status register's current outputs, because the status register loads all five flags at once.

Parameters:
- WIDTH, 8, datapath width. Flag rules below use bit WIDTH-1 as the sign bit.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  operation request; sampled only in IDLE
- op  in  4  opcode, captured on accepted start
- a  in  WIDTH  accumulator operand
- b  in  WIDTH  memory operand
- n_cur, z_cur, c_cur, b_cur, v_cur  in  1 each  current status-register flag outputs
- result  out  WIDTH  registered result
- n_in, z_in, c_in, b_in, v_in  out  1 each  flags presented to the status register
- load_flags_en  out  1  one-cycle flag load strobe
- acc_load  out  1  one-cycle accumulator write strobe
- busy  out  1  high in EXEC and DONE
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (synchronous, active-high): state=IDLE; result=0; all flag outputs=0; load_flags_en=0; acc_load=0; busy=0; done=0. Reset has priority over every other input.
- State machine:
  - IDLE, start=1: on that edge latch op, a, b and the five *_cur flags; go to EXEC.
  - EXEC: compute from the latched values; register result and flags; go to DONE.
  - DONE: done=1 and load_flags_en=1 for exactly this cycle. acc_load=1 if the op writes the accumulator. Then go to IDLE.
- Latency: start accepted at edge E0; outputs valid and strobes high in the cycle after E1; back in IDLE after E2. The status register captures the flags at E2.
- start is ignored while busy=1; it is never queued. Back-to-back operations: at most one per 3 cycles.
- result and flag outputs hold their values after DONE until the next completion. Strobes are 0 outside DONE.
- Opcodes (r = result; unlisted flags pass through from the latched *_cur):
  - 0 LDA: r=b; update N, Z.
  - 1 ADD: r=a+b; C=carry out; V=(a7==b7)&&(r7!=a7); update N, Z. B passes through.
  - 2 SUB: r=a-b; B=(a<b) unsigned; V=(a7!=b7)&&(r7!=a7); update N, Z. C passes through.
  - 3 OR, 4 AND: bitwise; update N, Z.
  - 5 NOT: r=~a; update N, Z.
  - 6 SHR: r={0,a[7:1]}, C=a[0]. 7 SHL: r={a[6:0],0}, C=a[7].
  - 8 ROR: r={c_cur,a[7:1]}, C=a[0]. 9 ROL: r={a[6:0],c_cur}, C=a[7].
  - Opcodes 6–9 update N, Z and C.
  - N=r[7]; Z=(r==0) for every op that updates them.
- acc_load=1 for ops 0–9.
- Unused opcodes (and 0xA when the optional feature is off):
  - done pulses; load_flags_en=0; acc_load=0.
  - result and flag outputs keep their previous values.
- Reset in EXEC or DONE: returns to IDLE at that edge; no done, load_flags_en or acc_load pulse is emitted afterwards.
- Wrap-around: all arithmetic is modulo 2^WIDTH; carry and borrow come from a WIDTH+1-bit computation.

Optional Feature:
- ALU_CMP_EN defined: opcode 0xA = CMP. Computes a-b with exactly the SUB flag rules (N, Z, V, B; C passes through). load_flags_en=1, acc_load=0. result output is still updated with the difference.
- ALU_CMP_EN undefined: 0xA is treated as an unused opcode.

Test Plan:
- ADD a=0x7F b=0x01, all *_cur=0 -> 2 cycles after start: result=0x80, NZCBV=10001, load_flags_en, acc_load and done each high for exactly 1 cycle.
- SUB a=0x00 b=0x01, c_cur=1 -> result=0xFF, NZCBV=10110 (C=1 preserved, B=1, V=0).
- ROR a=0x01 c_cur=1 -> result=0x80, NZCBV=10100. Then ROL a=0x80 c_cur=0 -> result=0x00, NZCBV=01100.
- AND a=0xF0 b=0x0F, c_cur=1 v_cur=1 b_cur=0 -> result=0x00, NZCBV=01101 (C and V passed through).
- Second start asserted in EXEC -> ignored, exactly one done pulse. Reset asserted in EXEC -> next cycle all outputs 0 and no strobe pulse. Opcode 0xF -> done only, load_flags_en=0 and acc_load=0.
- With ALU_CMP_EN: CMP a=0x05 b=0x05 -> NZCBV=01000 with *_cur=0, acc_load=0, load_flags_en=1. Without the macro: same stimulus -> no flag load.
